mod_n_counter: RTL and testbench

- Parametrised synchronous modulo-N counter. Successor to the fixed mod-200 two-nibble counter.
- Generalises width and modulus; adds up/down direction, count enable, synchronous parallel load, range-error flag and a registered wrap pulse.
- Used as a timebase/event counter. Cascades through C in the same way as 161-style terminal-count chains.

---
 rtl/cnt_pkg.sv | 59 +++++
 rtl/bcd_digit.sv | 36 +++
 rtl/mod_n_counter.sv | 117 +++++++++++
 tb/tb_mod_n_counter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Holds direction constants, terminal-value/BCD conversion helpers and parameter legality rules.
package cnt_pkg;

    localparam logic UP = 1'b1;
    localparam logic DN = 1'b0;

    function automatic longint unsigned term_value(input longint unsigned modulus, input logic up);
        return (up == UP) ? modulus - 64'd1 : 64'd0;
    endfunction

    function automatic longint unsigned bcd_to_bin(input logic [63:0] bcd);
        longint unsigned acc;
        acc = 64'd0;
        for (int k = 15; k >= 0; k--) begin
            acc = acc * 64'd10 + 64'(bcd[4*k +: 4]);
        end
        return acc;
    endfunction

    function automatic logic [63:0] bin_to_bcd(input longint unsigned value);
        logic [63:0] res;
        longint unsigned rem;
        res = '0;
        rem = value;
        for (int k = 0; k < 16; k++) begin
            res[4*k +: 4] = 4'(rem % 64'd10);
            rem = rem / 64'd10;
        end
        return res;
    endfunction

    function automatic logic bcd_valid(input logic [63:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (bcd[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    // BCD builds need whole digits; both builds cap width so 64-bit helpers never overflow.
    function automatic logic params_legal(input int unsigned width, input longint unsigned modulus,
                                          input logic is_bcd);
        if (modulus < 64'd2) return 1'b0;
        if (is_bcd) begin
            return (width % 4 == 0) && (width >= 4) && (width <= 60) && (modulus <= pow10(width / 4));
        end
        return (width >= 1) && (width <= 63) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of a packed-BCD up/down counter.
// Steps by one when carry-in is set and reports decade carry/borrow plus digit validity.
module bcd_digit (
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] next_digit,
    output logic       cout,
    output logic       valid
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= 4'd9) begin
                    next_digit = 4'd0;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    next_digit = 4'd9;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

    assign valid = (digit <= 4'd9);

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with load, terminal count, wrap and range-error pulses.
// Define MOD_BCD_EN to count in packed BCD instead of binary.
module mod_n_counter
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 200
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             CE,
    input  logic             UpDn,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             C,
    output logic             Wrap,
    output logic             Err
);

`ifdef MOD_BCD_EN
    localparam logic IS_BCD = 1'b1;
    localparam logic [63:0] TOP_ENC = bin_to_bcd(term_value(MODULUS, UP));
    localparam logic [63:0] BOT_ENC = bin_to_bcd(term_value(MODULUS, DN));
`else
    localparam logic IS_BCD = 1'b0;
    localparam logic [63:0] TOP_ENC = 64'(term_value(MODULUS, UP));
    localparam logic [63:0] BOT_ENC = 64'(term_value(MODULUS, DN));
`endif
    localparam logic [WIDTH-1:0] TOP_VAL = TOP_ENC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] BOT_VAL = BOT_ENC[WIDTH-1:0];

    if (!params_legal(WIDTH, MODULUS, IS_BCD)) begin : g_bad_params
        $error("mod_n_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] tv;
    logic             q_in_range;
    logic             d_in_range;

    assign tv = UpDn ? TOP_VAL : BOT_VAL;

`ifdef MOD_BCD_EN
    localparam int unsigned NDIG = WIDTH / 4;
    logic [NDIG:0]   carry;
    logic [NDIG-1:0] digit_ok;
    logic            carry_unused;

    // The low digit always steps; higher digits step only on a decade carry/borrow.
    assign carry[0]     = 1'b1;
    assign carry_unused = carry[NDIG];

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .digit      (q_q[4*g +: 4]),
            .up         (UpDn),
            .cin        (carry[g]),
            .next_digit (q_step[4*g +: 4]),
            .cout       (carry[g+1]),
            .valid      (digit_ok[g])
        );
    end

    assign q_in_range = (&digit_ok) && (bcd_to_bin(64'(q_q)) < MODULUS);
    assign d_in_range = bcd_valid(64'(D)) && (bcd_to_bin(64'(D)) < MODULUS);
`else
    assign q_step     = UpDn ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    assign q_in_range = (64'(q_q) < MODULUS);
    assign d_in_range = (64'(D) < MODULUS);
`endif

    // Load beats count; the terminal value is swapped for the opposite end to wrap modulo MODULUS.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (Load) begin
            if (d_in_range) begin
                q_d = D;
            end else begin
                q_d   = '0;
                err_d = 1'b1;
            end
        end else if (CE) begin
            if (!q_in_range) begin
                q_d = '0;
            end else if (q_q == tv) begin
                q_d    = UpDn ? BOT_VAL : TOP_VAL;
                wrap_d = 1'b1;
            end else begin
                q_d = q_step;
            end
        end
    end

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign C    = CE & (q_q == tv);
    assign Wrap = wrap_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: an integer reference model feeds expected queues, monitors compare.
// Also covers a MODULUS 10 x 20 cascade; honours MOD_BCD_EN by switching to a BCD encoding.
module tb_mod_n_counter;

`ifdef MOD_BCD_EN
    localparam int         MOD   = 60;
    localparam logic [7:0] BAD_D = 8'h3A;
`else
    localparam int         MOD   = 200;
    localparam logic [7:0] BAD_D = 8'd230;
`endif

    logic       Clk = 1'b0;
    logic       MR = 1'b0;
    logic       CE = 1'b0;
    logic       UpDn = 1'b1;
    logic       Load = 1'b0;
    logic [7:0] D = 8'd0;
    logic [7:0] Q;
    logic       C, Wrap, Err;

    logic       cas_ce = 1'b0;
    logic       cas_up = 1'b1;
    logic [7:0] lo_q, hi_q;
    logic       lo_c, hi_c, lo_wrap, hi_wrap, lo_err, hi_err;
    logic [7:0] zero_d = 8'd0;
    logic       no_load = 1'b0;

    int checks = 0;
    int failures = 0;
    int hi_wrap_seen = 0;

    typedef struct {
        int q;
        bit wrap;
        bit err;
        int cas;
        bit lo_wrap;
        bit hi_wrap;
    } exp_t;

    typedef struct {
        bit c;
        bit hi_c;
    } cexp_t;

    exp_t  sb[$];
    cexp_t cq[$];

    int m_q = 0;
    int m_cas = 0;

    mod_n_counter #(.WIDTH(8), .MODULUS(MOD)) dut (
        .Clk(Clk), .MR(MR), .CE(CE), .UpDn(UpDn), .Load(Load), .D(D),
        .Q(Q), .C(C), .Wrap(Wrap), .Err(Err)
    );

    mod_n_counter #(.WIDTH(8), .MODULUS(10)) u_lo (
        .Clk(Clk), .MR(MR), .CE(cas_ce), .UpDn(cas_up), .Load(no_load), .D(zero_d),
        .Q(lo_q), .C(lo_c), .Wrap(lo_wrap), .Err(lo_err)
    );

    mod_n_counter #(.WIDTH(8), .MODULUS(20)) u_hi (
        .Clk(Clk), .MR(MR), .CE(lo_c), .UpDn(cas_up), .Load(no_load), .D(zero_d),
        .Q(hi_q), .C(hi_c), .Wrap(hi_wrap), .Err(hi_err)
    );

    always #5 Clk = ~Clk;

    function automatic int dec(input logic [7:0] v);
`ifdef MOD_BCD_EN
        return int'(v[7:4]) * 10 + int'(v[3:0]);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [7:0] enc(input int n);
`ifdef MOD_BCD_EN
        return {4'(n / 10), 4'(n % 10)};
`else
        return 8'(n);
`endif
    endfunction

    function automatic bit d_ok(input logic [7:0] v);
`ifdef MOD_BCD_EN
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 1'b0;
`endif
        return dec(v) < MOD;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and queues what the model says should follow.
    task automatic apply_stimulus(input bit ce, input bit up, input bit ld, input logic [7:0] d,
                                  input bit cce, input bit cup);
        exp_t  e;
        cexp_t ce_e;
        @(negedge Clk);
        CE = ce; UpDn = up; Load = ld; D = d; cas_ce = cce; cas_up = cup;
        #1;
        ce_e.c    = ce && (m_q == (up ? MOD - 1 : 0));
        ce_e.hi_c = cce && (m_cas == (cup ? 199 : 0));
        cq.push_back(ce_e);

        e.wrap = 1'b0;
        e.err  = 1'b0;
        if (ld) begin
            if (d_ok(d)) m_q = dec(d);
            else begin
                m_q   = 0;
                e.err = 1'b1;
            end
        end else if (ce) begin
            if (up) begin
                e.wrap = (m_q == MOD - 1);
                m_q    = (m_q + 1) % MOD;
            end else begin
                e.wrap = (m_q == 0);
                m_q    = (m_q + MOD - 1) % MOD;
            end
        end
        e.q = m_q;

        e.lo_wrap = cce && (cup ? (m_cas % 10 == 9) : (m_cas % 10 == 0));
        e.hi_wrap = cce && (cup ? (m_cas == 199) : (m_cas == 0));
        if (cce) m_cas = cup ? (m_cas + 1) % 200 : (m_cas + 199) % 200;
        e.cas = m_cas;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        CE = 1'b0; Load = 1'b0; cas_ce = 1'b0;
        MR = 1'b1;
        #1;
        check_output("reset_q", int'(Q), 0);
        check_output("reset_wrap", int'(Wrap), 0);
        check_output("reset_err", int'(Err), 0);
        check_output("reset_cascade", dec(hi_q) * 10 + dec(lo_q), 0);
        m_q   = 0;
        m_cas = 0;
        @(negedge Clk);
        MR = 1'b0;
    endtask

    initial begin : monitor_regs
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (hi_wrap) hi_wrap_seen++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("q", int'(Q), int'(enc(e.q)));
                check_output("wrap", int'(Wrap), int'(e.wrap));
                check_output("err", int'(Err), int'(e.err));
                check_output("cascade_q", dec(hi_q) * 10 + dec(lo_q), e.cas);
                check_output("lo_wrap", int'(lo_wrap), int'(e.lo_wrap));
                check_output("hi_wrap", int'(hi_wrap), int'(e.hi_wrap));
                check_output("cascade_err", int'(lo_err | hi_err), 0);
            end
        end
    end

    initial begin : monitor_comb
        cexp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                check_output("c", int'(C), int'(e.c));
                check_output("hi_c", int'(hi_c), int'(e.hi_c));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        bit         ce, up, ld, cce, cup;
        logic [7:0] d;

        reset_dut();

        // Full up sweep across the terminal value and wrap.
        repeat (MOD + 5) apply_stimulus(1, 1, 0, 8'd0, 1, 1);
        repeat (37) apply_stimulus(1, 1, 0, 8'd0, 1, 1);
        reset_dut();

        // Down from zero wraps to the top.
        apply_stimulus(1, 0, 0, 8'd0, 1, 0);
        apply_stimulus(1, 0, 0, 8'd0, 1, 0);

        // Load priority over count, then an out-of-range load.
        apply_stimulus(1, 1, 1, enc(50 % MOD), 0, 1);
        apply_stimulus(1, 1, 1, enc(120 % MOD), 0, 1);
        apply_stimulus(1, 1, 0, 8'd0, 0, 1);
        apply_stimulus(1, 1, 1, BAD_D, 0, 1);
        apply_stimulus(0, 1, 0, 8'd0, 0, 1);

        // Hold, then direction change around 10.
        apply_stimulus(0, 1, 1, enc(7), 0, 1);
        repeat (5) apply_stimulus(0, 1, 0, 8'd0, 0, 1);
        apply_stimulus(0, 1, 1, enc(10), 0, 1);
        apply_stimulus(1, 1, 0, 8'd0, 0, 1);
        apply_stimulus(1, 1, 0, 8'd0, 0, 1);
        apply_stimulus(1, 0, 0, 8'd0, 0, 0);
        apply_stimulus(1, 0, 0, 8'd0, 0, 0);

        // Approach the wrap from a loaded value near the top.
        apply_stimulus(0, 1, 1, enc(MOD - 3), 0, 1);
        repeat (4) apply_stimulus(1, 1, 0, 8'd0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            ce  = ($urandom_range(0, 3) != 0);
            up  = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 15) == 0);
            d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : enc($urandom_range(0, MOD - 1));
            cce = ($urandom_range(0, 3) != 0);
            cup = 1'($urandom_range(0, 1));
            apply_stimulus(ce, up, ld, d, cce, cup);
        end

        // Cascade: two full periods should give exactly two high-stage wraps.
        reset_dut();
        hi_wrap_seen = 0;
        repeat (400) apply_stimulus(0, 1, 0, 8'd0, 1, 1);
        @(negedge Clk);
        @(negedge Clk);
        check_output("cascade_wrap_count", hi_wrap_seen, 2);
        check_output("scoreboard_drained", sb.size() + cq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
